// File: rtl/tt_sweep.sv
// Sequential truth-table evaluator: sweeps all 2^N input vectors
// and streams each minterm or maxterm over a valid/ready port.
module tt_sweep #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2**N-1:0]   tt_in,
  input  logic              mode,
  input  logic              term_ready,
  output logic              term_valid,
  output logic [N-1:0]      vec_out,
  output logic              f_out,
  output logic [N:0]        term_count,
  output logic              busy,
  output logic              done
);

  localparam int W = 2**N;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] tt;
  logic         mode_q;
  logic [N-1:0] idx;

  logic slot_free;
  logic tt_bit;
  logic match;
  logic last;

  assign slot_free = !term_valid || term_ready;
  assign tt_bit    = tt[idx];
  assign match     = tt_bit ^ mode_q;
  assign last      = &idx;

  assign busy = (state == SCAN) || (state == FLUSH);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tt         <= '0;
      mode_q     <= 1'b0;
      idx        <= '0;
      term_valid <= 1'b0;
      vec_out    <= '0;
      f_out      <= 1'b0;
      term_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tt         <= tt_in;
            mode_q     <= mode;
            idx        <= '0;
            term_count <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          // a stalled term blocks evaluation so nothing is dropped
          if (slot_free) begin
            if (match) begin
              vec_out    <= idx;
              f_out      <= tt_bit;
              term_valid <= 1'b1;
              term_count <= term_count + (N+1)'(1);
            end else begin
              term_valid <= 1'b0;
            end
            idx <= idx + N'(1);
            if (last) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (slot_free) begin
            term_valid <= 1'b0;
            state      <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboard bench for tt_sweep: directed tables, stalls,
// mid-sweep reset and ignored restarts.
module tb_tt_sweep;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] tt_in;
  logic        mode;
  logic        term_ready;
  logic        term_valid;
  logic [3:0]  vec_out;
  logic        f_out;
  logic [4:0]  term_count;
  logic        busy;
  logic        done;

  tt_sweep #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tt_in(tt_in),
    .mode(mode),
    .term_ready(term_ready),
    .term_valid(term_valid),
    .vec_out(vec_out),
    .f_out(f_out),
    .term_count(term_count),
    .busy(busy),
    .done(done)
  );

  int total = 0;
  int bad = 0;

  logic [4:0] q[$];
  bit         sb_en = 1'b1;
  bit         stall_pend = 1'b0;
  logic [4:0] stall_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops one expected term per transfer
  always @(negedge clk) begin
    logic [4:0] e;
    if (stall_pend) begin
      chk("stall_valid", int'(term_valid), 1);
      chk("stall_hold", int'({vec_out, f_out}), int'(stall_val));
      stall_pend = 1'b0;
    end
    if (sb_en && term_valid && term_ready) begin
      if (q.size() == 0) begin
        chk("extra_term", int'({vec_out, f_out}), -1);
      end else begin
        e = q.pop_front();
        chk("term", int'({vec_out, f_out}), int'(e));
      end
    end else if (sb_en && term_valid) begin
      stall_pend = 1'b1;
      stall_val  = {vec_out, f_out};
    end
  end

  task automatic run(input logic [15:0] t, input logic md,
                     input int exp_cnt, input bit tog, input int inj);
    int k;
    for (int i = 0; i < 16; i++)
      if (t[i] ^ md) q.push_back({4'(i), t[i]});
    @(posedge clk); #1;
    tt_in = t; mode = md; start = 1'b1; term_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tt_in = ~t; mode = ~md;
    chk("start_busy", int'(busy), 1);
    chk("start_count", int'(term_count), 0);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (!done) begin
        if (tog) term_ready = ~term_ready;
        if (k == inj) begin
          start = 1'b1; tt_in = 16'h1234; mode = 1'b0;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (k >= 100) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (!tog) chk("latency", k, 17);
      chk("count", int'(term_count), exp_cnt);
      chk("q_empty", q.size(), 0);
      chk("done_busy", int'(busy), 0);
    end
    term_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("count_hold", int'(term_count), exp_cnt);
    q.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; tt_in = '0; mode = 1'b0; term_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", int'(term_valid), 0);
    chk("rst_count", int'(term_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    run(16'h8001, 1'b0, 2, 1'b0, 0);
    run(16'h8001, 1'b1, 14, 1'b0, 0);
    run(16'h0000, 1'b0, 0, 1'b0, 0);
    run(16'hFFFF, 1'b0, 16, 1'b1, 0);
    run(16'hA5C3, 1'b1, 8, 1'b1, 0);

    // reset with idx=7 in SCAN
    sb_en = 1'b0;
    @(posedge clk); #1;
    tt_in = 16'hFFFF; mode = 1'b0; start = 1'b1; term_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_vec", int'(vec_out), 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", int'(term_valid), 0);
    chk("mid_rst_vec", int'(vec_out), 0);
    chk("mid_rst_f", int'(f_out), 0);
    chk("mid_rst_count", int'(term_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_rst", int'(seen), 0);
    stall_pend = 1'b0;
    q.delete();
    sb_en = 1'b1;

    run(16'h8001, 1'b1, 14, 1'b0, 0);
    run(16'h0F0F, 1'b0, 8, 1'b0, 5);
    run(16'h8001, 1'b0, 2, 1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tt_sweep.md
Name: tt_sweep

Overview:
Parametrised sequential truth-table evaluator for an N-input Boolean function. It latches a 2^N-bit truth table and sweeps every input combination, index 0 to 2^N-1, one per clock. Each matching term (minterm or maxterm, selected by mode) is emitted on a valid/ready stream, and the matches are counted. It replaces fixed hand-written sum-of-products/product-of-sums gates in the lab designs with one reusable, programmable block.

Parameters:
N, 4, number of function inputs (1..8); truth table width is 2^N.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; sampled only in IDLE
tt_in  input  2^N  truth table; bit i = F for input vector i
mode  input  1  0 = report minterms (F=1), 1 = report maxterms (F=0); sampled with start
term_ready  input  1  downstream accepts the current term
term_valid  output  1  vec_out/f_out hold a reported term
vec_out  output  N  input vector of the reported term
f_out  output  1  F value at vec_out
term_count  output  N+1  number of matching terms found in the current/last sweep
busy  output  1  high in SCAN and FLUSH
done  output  1  one-cycle pulse at sweep end

Behaviour:
- One clock, synchronous active-high reset. On rst=1 at a clock edge:
  - state=IDLE;
  - term_valid, vec_out, f_out, term_count, busy and done all become 0;
  - the internal index and latched table/mode are cleared.
  - Reset has priority over everything, including mid-sweep: the sweep is abandoned and no done pulse is produced.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - start=1 latches tt_in and mode, sets idx=0 and term_count=0, then goes to SCAN.
  - Otherwise the block holds; term_count keeps the last result.
- SCAN, output slot free (term_valid=0, or term_valid=1 and term_ready=1):
  - Evaluate bit = tt[idx]; match = (mode==0) ? bit : ~bit.
  - On match: vec_out<=idx, f_out<=bit, term_valid<=1, term_count<=term_count+1.
  - On no match: term_valid<=0.
  - idx<=idx+1. If idx was 2^N-1, go to FLUSH instead (idx wrap is not used).
- SCAN, output slot stalled (term_valid=1, term_ready=0):
  - idx, the outputs and term_count hold. No evaluation and no term loss.
- FLUSH:
  - Go to DONE once the slot is free (term_valid=0, or term_valid&term_ready). term_valid<=0 on that edge.
  - Otherwise hold.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Handshake:
  - A transfer is term_valid&term_ready at a rising edge.
  - vec_out and f_out are stable while term_valid=1 and not yet transferred.
  - term_valid never drops without a transfer (reset excepted).
- start while busy or in DONE is ignored. tt_in and mode changes during a sweep have no effect.
- Latency with term_ready held at 1:
  - done is high in the cycle after the (2^N+1)th rising edge following the edge that sampled start.
  - Terms appear in ascending index order, at most one per cycle.
- term_count is N+1 bits, so 2^N matches fit without overflow. It is valid when done pulses and holds until the next accepted start.

Test Plan:
- N=4, tt_in=16'h8001, mode=0, term_ready=1 -> terms vec 0 then vec 15, f_out=1; term_count=2; done 17 cycles after the start edge.
- N=4, tt_in=16'h8001, mode=1 -> 14 terms, vec 1..14 ascending, f_out=0; term_count=14.
- tt_in=0, mode=0 -> term_valid never asserts; term_count=0; done still pulses once at the same latency.
- tt_in=16'hFFFF, mode=0, term_ready toggling 1,0,1,0... -> all 16 vectors delivered exactly once in order; vec_out is stable during stalls; term_count=16.
- Assert rst during SCAN at idx=7 -> next cycle all outputs 0 and state IDLE; no done pulse; a new start runs a full sweep correctly.
- Pulse start mid-sweep with a different tt_in -> ignored; results match the original table; start in IDLE afterwards clears term_count to 0.
